// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared constants and helpers for the pipeline hazard responder.
// Holds forward-select codes, result-source codes and shadow-entry field widths.
// Helpers map a result source to its initial Tnew and step Tnew down per stage.
package hazard_unit_pkg;

  // Forward-mux select codes, ordered by producing stage.
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  // Where the D-stage instruction's result comes from.
  localparam logic [1:0] SRC_PC8 = 2'd0;
  localparam logic [1:0] SRC_ALU = 2'd1;
  localparam logic [1:0] SRC_MEM = 2'd2;

  // Shadow-entry field widths.
  localparam int TNEW_W = 2;
  localparam int SEL_W  = 2;

  typedef logic [TNEW_W-1:0] tnew_t;

  // Cycles, counted from E, until the result exists; the reserved code 3 behaves as memory.
  function automatic tnew_t tnew_from_src(input logic [1:0] src);
    tnew_t t;
    case (src)
      SRC_PC8: t = 2'd0;
      SRC_ALU: t = 2'd1;
      default: t = 2'd2;
    endcase
    return t;
  endfunction

  // One pipeline advance brings the result one cycle closer, never below zero.
  function automatic tnew_t tnew_step(input tnew_t t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: per-operand forwarding priority mux (youngest ready producer wins).
// A candidate stage supplies data only if its address matches and its result is ready.
// Disabled candidates (use_e/use_m low) are skipped; register 0 never forwards.
module hazard_fwd_sel
  import hazard_unit_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] src,
  input  logic              use_e,
  input  logic [ADDR_W-1:0] addr_e,
  input  tnew_t             tnew_e,
  input  logic              use_m,
  input  logic [ADDR_W-1:0] addr_m,
  input  tnew_t             tnew_m,
  input  logic [ADDR_W-1:0] addr_w,
  output logic [SEL_W-1:0]  sel
);

  // Oldest first so that each younger ready match overrides it.
  always_comb begin
    sel = FWD_RF;
    if (src != '0) begin
      if (src == addr_w)
        sel = FWD_W;
      if (use_m && src == addr_m && tnew_m == 2'd0)
        sel = FWD_M;
      if (use_e && src == addr_e && tnew_e == 2'd0)
        sel = FWD_E;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: D-stage stall and forwarding-select generator for the 5-stage MIPS pipeline.
// Keeps a shadow E/M/W copy of destination, Tnew and sources; stall and selects are combinational.
// Optional HAZARD_STALL_CNT_EN adds a saturating stall_cnt output counting stalled cycles.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int ADDR_W = 5
`ifdef HAZARD_STALL_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_D,
  input  logic [ADDR_W-1:0] rt_D,
  input  logic              h_D1,
  input  logic              h_D2,
  input  logic              h_E1,
  input  logic              h_E2,
  input  logic              h_MU,
  input  logic [ADDR_W-1:0] a_WD_s_D,
  input  logic [1:0]        src_D,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_D1,
  output logic [SEL_W-1:0]  fwd_D2,
  output logic [SEL_W-1:0]  fwd_E1,
  output logic [SEL_W-1:0]  fwd_E2,
  output logic [SEL_W-1:0]  fwd_M2
`ifdef HAZARD_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  // Shadow pipeline; W only needs its address since its Tnew is always zero.
  logic [ADDR_W-1:0] addr_e, rs_e, rt_e;
  tnew_t             tnew_e;
  logic [ADDR_W-1:0] addr_m, rt_m;
  tnew_t             tnew_m;
  logic [ADDR_W-1:0] addr_w;

  logic              need_rs, need_rt, hz_rs, hz_rt;
  tnew_t             tuse_rs, tuse_rt;
  logic [SEL_W-1:0]  sel_d1, sel_d2, sel_e1, sel_e2, sel_m2;

  // Stall when a needed source's producer in E or M will not be ready by its Tuse.
  always_comb begin
    need_rs = h_D1 | h_E1;
    tuse_rs = h_D1 ? 2'd0 : 2'd1;
    need_rt = h_D2 | h_E2 | h_MU;
    tuse_rt = h_D2 ? 2'd0 : (h_E2 ? 2'd1 : 2'd2);
    hz_rs   = need_rs && (rs_D != '0) &&
              ((rs_D == addr_e && tnew_e > tuse_rs) || (rs_D == addr_m && tnew_m > tuse_rs));
    hz_rt   = need_rt && (rt_D != '0) &&
              ((rt_D == addr_e && tnew_e > tuse_rt) || (rt_D == addr_m && tnew_m > tuse_rt));
    stall   = !reset && (hz_rs || hz_rt);
  end

  // D operands see E, M and W, since the register file has no write-through bypass.
  hazard_fwd_sel #(.ADDR_W(ADDR_W)) u_sel_d1 (
    .src(rs_D), .use_e(1'b1), .addr_e(addr_e), .tnew_e(tnew_e),
    .use_m(1'b1), .addr_m(addr_m), .tnew_m(tnew_m), .addr_w(addr_w), .sel(sel_d1));
  hazard_fwd_sel #(.ADDR_W(ADDR_W)) u_sel_d2 (
    .src(rt_D), .use_e(1'b1), .addr_e(addr_e), .tnew_e(tnew_e),
    .use_m(1'b1), .addr_m(addr_m), .tnew_m(tnew_m), .addr_w(addr_w), .sel(sel_d2));

  // E operands see M and W only.
  hazard_fwd_sel #(.ADDR_W(ADDR_W)) u_sel_e1 (
    .src(rs_e), .use_e(1'b0), .addr_e('0), .tnew_e(2'd0),
    .use_m(1'b1), .addr_m(addr_m), .tnew_m(tnew_m), .addr_w(addr_w), .sel(sel_e1));
  hazard_fwd_sel #(.ADDR_W(ADDR_W)) u_sel_e2 (
    .src(rt_e), .use_e(1'b0), .addr_e('0), .tnew_e(2'd0),
    .use_m(1'b1), .addr_m(addr_m), .tnew_m(tnew_m), .addr_w(addr_w), .sel(sel_e2));

  // Store data in M can only come from W.
  hazard_fwd_sel #(.ADDR_W(ADDR_W)) u_sel_m2 (
    .src(rt_m), .use_e(1'b0), .addr_e('0), .tnew_e(2'd0),
    .use_m(1'b0), .addr_m('0), .tnew_m(2'd0), .addr_w(addr_w), .sel(sel_m2));

  // Selects are forced to the register-file path while reset is held.
  always_comb begin
    fwd_D1 = reset ? FWD_RF : sel_d1;
    fwd_D2 = reset ? FWD_RF : sel_d2;
    fwd_E1 = reset ? FWD_RF : sel_e1;
    fwd_E2 = reset ? FWD_RF : sel_e2;
    fwd_M2 = reset ? FWD_RF : sel_m2;
  end

  // Advance the shadow pipeline; a stall injects an all-zero bubble into E.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_e <= '0;
      rs_e   <= '0;
      rt_e   <= '0;
      tnew_e <= 2'd0;
      addr_m <= '0;
      rt_m   <= '0;
      tnew_m <= 2'd0;
      addr_w <= '0;
    end else begin
      addr_w <= addr_m;
      addr_m <= addr_e;
      rt_m   <= rt_e;
      tnew_m <= tnew_step(tnew_e);
      if (stall) begin
        addr_e <= '0;
        rs_e   <= '0;
        rt_e   <= '0;
        tnew_e <= 2'd0;
      end else begin
        addr_e <= a_WD_s_D;
        rs_e   <= rs_D;
        rt_e   <= rt_D;
        tnew_e <= tnew_from_src(src_D);
      end
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  // Count stalled cycles, holding at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end
`endif

endmodule
